ifu_pc: RTL and testbench

- Program-counter stage that sits directly upstream of the instruction memory in the single-cycle MIPS datapath.
- Holds the architectural PC and computes the next PC (sequential, branch, jump, jump-register).
- Drives the byte PC and a word index to the instruction memory.
- Traps illegal fetch targets with a sticky fault and counts committed PC updates.

---
 rtl/ifu_pc.sv | 97 +++++++++
 tb/tb_ifu_pc.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ifu_pc.sv
// Program-counter stage for the single-cycle MIPS fetch path: next-PC select,
// fetch-window legality check, sticky fault capture and a commit counter.
module ifu_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  npc_op,
  input  logic        br_cond,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [11:0] word_addr,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] commit_cnt
);

  // Upper bound kept in 33 bits so a window ending at 2^32 still compares correctly.
  localparam logic [32:0] WIN_LO = {1'b0, RESET_PC};
  localparam logic [32:0] WIN_HI = {1'b0, RESET_PC} + (33'(IM_WORDS) << 2);

  typedef enum logic [2:0] {
    OP_SEQ  = 3'd0,
    OP_BR   = 3'd1,
    OP_JUMP = 3'd2,
    OP_JR   = 3'd3
  } npc_op_e;

  logic [31:0] pc_q, pc_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [31:0] commit_cnt_q, commit_cnt_d;

  logic [31:0] br_off;
  logic [31:0] tgt;
  logic        tgt_legal;

  always_comb begin
    pc_plus4  = pc_q + 32'd4;
    word_addr = 12'((pc_q - RESET_PC) >> 2);
    br_off    = {{14{imm16[15]}}, imm16, 2'b00};

    tgt = pc_plus4;
    case (npc_op_e'(npc_op))
      OP_BR:   tgt = br_cond ? (pc_plus4 + br_off) : pc_plus4;
      OP_JUMP: tgt = {pc_plus4[31:28], imm26, 2'b00};
      OP_JR:   tgt = rs_data;
      default: tgt = pc_plus4;
    endcase

    tgt_legal = (tgt[1:0] == 2'b00) &&
                ({1'b0, tgt} >= WIN_LO) &&
                ({1'b0, tgt} <  WIN_HI);
  end

  // Fault freezes everything; stall skips the legality check entirely.
  always_comb begin
    pc_d         = pc_q;
    fault_d      = fault_q;
    fault_pc_d   = fault_pc_q;
    commit_cnt_d = commit_cnt_q;
    if (!fault_q && !stall) begin
      if (tgt_legal) begin
        pc_d         = tgt;
        commit_cnt_d = commit_cnt_q + 32'd1;
      end else begin
        fault_d    = 1'b1;
        fault_pc_d = tgt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      fault_q      <= 1'b0;
      fault_pc_q   <= 32'd0;
      commit_cnt_q <= 32'd0;
    end else begin
      pc_q         <= pc_d;
      fault_q      <= fault_d;
      fault_pc_q   <= fault_pc_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end

  assign pc         = pc_q;
  assign fault      = fault_q;
  assign fault_pc   = fault_pc_q;
  assign commit_cnt = commit_cnt_q;

endmodule

// File: tb/tb_ifu_pc.sv
// Scoreboard bench for ifu_pc: directed scenarios then randomized traffic,
// checked against an arithmetic model of the fetch-window rules.
module tb_ifu_pc;

  localparam logic [31:0] RPC   = 32'h0000_3000;
  localparam longint      WORDS = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  npc_op = 3'd0;
  logic        br_cond = 1'b0;
  logic [15:0] imm16 = 16'd0;
  logic [25:0] imm26 = 26'd0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] pc, pc_plus4, fault_pc, commit_cnt;
  logic [11:0] word_addr;
  logic        fault;

  ifu_pc #(.RESET_PC(RPC), .IM_WORDS(4096)) dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_op(npc_op),
    .br_cond(br_cond), .imm16(imm16), .imm26(imm26), .rs_data(rs_data),
    .pc(pc), .pc_plus4(pc_plus4), .word_addr(word_addr), .fault(fault),
    .fault_pc(fault_pc), .commit_cnt(commit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        fault;
    logic [31:0] fpc;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference state, advanced once per applied cycle.
  logic [31:0] m_pc = 32'd0, m_fpc = 32'd0, m_cnt = 32'd0;
  logic        m_fault = 1'b0;

  function automatic logic [31:0] model_target(logic [31:0] cur, logic [2:0] op, logic br,
                                               logic [15:0] i16, logic [25:0] i26,
                                               logic [31:0] rs);
    longint seq;
    seq = longint'(cur) + 4;
    if (op == 3'd1 && br)
      return 32'(seq + 4 * longint'($signed(i16)));
    if (op == 3'd2)
      return 32'((seq % 64'h1_0000_0000) / 64'h1000_0000 * 64'h1000_0000 + 4 * longint'(i26));
    if (op == 3'd3)
      return rs;
    return 32'(seq);
  endfunction

  function automatic bit model_legal(logic [31:0] t);
    return (longint'(t) % 4 == 0) && (longint'(t) >= longint'(RPC)) &&
           (longint'(t) < longint'(RPC) + 4 * WORDS);
  endfunction

  task automatic applyStimulus(input logic rst, input logic stl, input logic [2:0] op,
                               input logic br, input logic [15:0] i16,
                               input logic [25:0] i26, input logic [31:0] rs);
    logic [31:0] t;
    exp_t e;
    @(negedge clk);
    reset = rst; stall = stl; npc_op = op; br_cond = br;
    imm16 = i16; imm26 = i26; rs_data = rs;
    if (rst) begin
      m_pc = RPC; m_fault = 1'b0; m_fpc = 32'd0; m_cnt = 32'd0;
    end else if (!m_fault && !stl) begin
      t = model_target(m_pc, op, br, i16, i26, rs);
      if (model_legal(t)) begin
        m_pc = t;
        m_cnt = m_cnt + 32'd1;
      end else begin
        m_fault = 1'b1;
        m_fpc = t;
      end
    end
    e.pc = m_pc; e.fault = m_fault; e.fpc = m_fpc; e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      n_err++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents a new registered state after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        checkOutput("pc", pc, e.pc);
        checkOutput("pc_plus4", pc_plus4, e.pc + 32'd4);
        checkOutput("word_addr", {20'd0, word_addr},
                    32'(((longint'(e.pc) - longint'(RPC)) / 4) & 64'hFFF));
        checkOutput("fault", {31'd0, fault}, {31'd0, e.fault});
        checkOutput("fault_pc", fault_pc, e.fpc);
        checkOutput("commit_cnt", commit_cnt, e.cnt);
      end
    end
  end

  initial begin
    int k;
    logic [2:0]  op;
    logic [15:0] i16;
    logic [25:0] i26;
    logic [31:0] rs;

    // Reset then sequential fetch, branches taken and not taken.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 16'hFFFC, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 16'hFFFC, 0, 0);
    applyStimulus(0, 0, 1, 1, 16'hFFFF, 0, 0);
    applyStimulus(0, 0, 5, 1, 16'hFFFF, 0, 0);

    // Jump and jr from a fresh reset.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 2, 0, 0, 26'h0000C10, 0);
    applyStimulus(0, 0, 3, 0, 0, 0, 32'h3004);

    // Stalled misaligned jr never faults; released it does, then freezes.
    applyStimulus(0, 1, 3, 0, 0, 0, 32'h3002);
    applyStimulus(0, 1, 3, 0, 0, 0, 32'h3002);
    applyStimulus(0, 0, 3, 0, 0, 0, 32'h3002);
    repeat (5) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);

    // Top of the window: falling off the end faults with fault_pc = 7000.
    applyStimulus(0, 0, 3, 0, 0, 0, 32'h6FFC);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 3, 0, 0, 0, 32'h2FFC);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 3, 0, 0, 0, 32'h2FFC);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 600; n++) begin
      op  = 3'($urandom_range(0, 7));
      k   = int'($urandom_range(0, 40)) - 20;
      i16 = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'(k);
      i26 = 26'($urandom_range('h0A00, 'h1C40));
      case ($urandom_range(0, 5))
        0:       rs = $urandom;
        1:       rs = RPC + 32'($urandom_range(0, 16383));
        default: rs = RPC + 32'($urandom_range(0, 4095) << 2);
      endcase
      applyStimulus((m_fault && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0,
                    $urandom_range(0, 4) == 0, op, 1'($urandom), i16, i26, rs);
    end

    begin
      int budget;
      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        #2;
        budget--;
      end
      if (exp_q.size() > 0) begin
        n_err++;
        $display("[TB] FAIL drain: %0d expected states left, expected 0", exp_q.size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
